rv_inst_encoder: RTL and testbench
==================================

# rv_inst_encoder

- Encodes RV32I instruction descriptors (format class, opcode, register fields, funct3/funct7, immediate) into 32-bit instruction words.
- Writes the words sequentially into instruction memory through a small FIFO.
- It is the inverse of the instruction decoder/controller. It is used by the program loader and the self-test harness to fill instruction memory before the core is released from reset.

## Interface

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after start

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a load session (honoured in IDLE/DONE only)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready at rising edge
- in_type  in  3  000 I, 001 S, 010 B, 011 J, 100 R, 101 U; 110/111 illegal
- in_op  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3
- in_funct7  in  7
- in_imm  in  32  immediate, byte-offset form (B/J bit 0 ignored; U uses imm[31:12])
- in_last  in  1  marks final descriptor of the session
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- busy  out  1  state is LOAD or DRAIN
- done  out  1  high in DONE
- err  out  1  sticky error, cleared by start or reset

## Operation

- Encoding uses the standard RV32I field placement. It is combinational on the input fields and registered into the FIFO on acceptance.
  - I: imm[11:0] rs1 f3 rd op
  - S: imm[11:5] rs2 rs1 f3 imm[4:0] op
  - B: imm[12] imm[10:5] rs2 rs1 f3 imm[4:1] imm[11] op
  - J: imm[20] imm[10:1] imm[11] imm[19:12] rd op
  - R: f7 rs2 rs1 f3 rd op
  - U: imm[31:12] rd op
- Fields not used by the format are ignored. in_op is placed verbatim and is not checked against in_type.
- State machine:
  - IDLE → LOAD on start: address ← BASE_ADDR, err ← 0.
  - LOAD: in_ready = !full. Accepting a descriptor with in_last → DRAIN.
  - DRAIN: in_ready = 0. When the FIFO is empty → DONE.
  - DONE: done = 1. start → LOAD, same actions as from IDLE.
- start is ignored in LOAD and DRAIN.
- Illegal in_type: the descriptor is accepted (handshake completes) and dropped. Nothing is written and err is set. If in_last is set, the transition to DRAIN still occurs.
- Write port:
  - imem_we = !empty && (LOAD || DRAIN). imem_wdata is the FIFO head, imem_addr is the address counter.
  - On imem_we && imem_ready: pop, and address increments.
  - If the address is all-ones, it wraps to 0 and err is set; the write itself still completes.
- in_ready does not anticipate a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
- When push and pop occur together with the FIFO not full, both take effect and occupancy is unchanged.

## Timing

- Reset values: state IDLE, FIFO empty, address BASE_ADDR, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0.
- Reset mid-session flushes the FIFO and drops any unwritten words. imem_we deasserts immediately, because reset is asynchronous.
- Latency: a descriptor accepted at edge N is presented with imem_we = 1 in the cycle after N. It is written at edge N+1 if imem_ready is high.
- Throughput: one descriptor and one write per cycle.
- in_ready rises the cycle after the start edge.
- done rises the cycle after the final pop.
- Memory-side hold: imem_addr and imem_wdata are held stable while imem_we && !imem_ready.

## Configuration

- RV_ENC_IMM_CHECK_EN defined: range-check the immediate per format. A violation sets err and drops the descriptor, with the same handshake behaviour as an illegal type.
  - I/S: signed 12-bit.
  - B: signed 13-bit, bit 0 = 0.
  - J: signed 21-bit, bit 0 = 0.
  - U: imm[11:0] = 0.
- Undefined: immediates are silently truncated to the format. Immediates never set err.

## Test plan

- start, then addi x1,x0,5 (I, op 0010011, rd 1, f3 000, imm 5, last) → imem_addr 0 written with 0x00500093 one cycle after acceptance; done follows.
- R add x3,x1,x2 (f7 0) then sub (f7 0x20) → 0x002081B3 at addr 0, 0x402081B3 at addr 1.
- S sw x2,8(x1) → 0x0020A423; B beq x1,x2,-4 → 0xFE208EE3; J jal x1,8 → 0x008000EF; U lui x5 imm 0x12345000 → 0x123452B7; all written at consecutive addresses.
- imem_ready = 0, offer 5 descriptors → in_ready drops after 4 accepted. Raise imem_ready → words land at addrs 0–4 in order, the 5th accepted once not full.
- in_type 110 mid-stream → err = 1, no write, address unchanged. Assert reset during DRAIN → imem_we, busy, err all 0 immediately; a later start restarts at BASE_ADDR.
- With RV_ENC_IMM_CHECK_EN: addi imm 2048 → err = 1, dropped. Without the macro: the same descriptor is written as 0x80000093.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// Purpose: encodes RV32I instruction descriptors into 32-bit words and streams them into instruction memory.
// Latency: a descriptor accepted at edge N is offered to memory (imem_we=1) in the cycle after N.
// Backpressure: in_ready = LOAD && FIFO not full; imem_ready low holds imem_addr/imem_wdata and fills the FIFO.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 begins a load session (honoured in IDLE/DONE only)
//   in_valid/in_ready     descriptor handshake; in_type/in_op/in_rd/in_rs1/in_rs2/
//                         in_funct3/in_funct7/in_imm/in_last form the descriptor
//   imem_we/imem_ready    write handshake; imem_addr/imem_wdata carry word address and data
//   busy, done, err       session status; err is sticky until start or reset
//
// Configuration macro: RV_ENC_IMM_CHECK_EN -- when defined, out-of-range immediates are
// dropped and flag err; when undefined, immediates are truncated to the format silently.

// Small generic FIFO used as the elastic buffer between encoder and memory port.
// Latency: pushed data is visible at the head on the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module rv_inst_encoder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic             single
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] ONE = 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign single  = ((wr_ptr - rd_ptr) == ONE);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_dat;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module rv_inst_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [2:0] FMT_R = 3'd4;
    localparam logic [2:0] FMT_U = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc_dat;
    logic              fmt_ok;
    logic              imm_ok;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_single;
    logic [31:0]       fifo_head;

    // ------------------------------------------------------------------
    // Field placement. in_op goes through untouched; unused fields of a
    // format are simply not referenced for that format.
    // ------------------------------------------------------------------
    always_comb begin
        enc_dat = '0;
        case (in_type)
            FMT_I: enc_dat = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            FMT_S: enc_dat = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:0], in_op};
            FMT_B: enc_dat = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_op};
            FMT_J: enc_dat = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_op};
            FMT_R: enc_dat = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            FMT_U: enc_dat = {in_imm[31:12], in_rd, in_op};
            default: enc_dat = '0;
        endcase
    end

    // Codes 110/111 have no format.
    assign fmt_ok = (in_type <= FMT_U);

`ifdef RV_ENC_IMM_CHECK_EN
    // An immediate fits a signed N-bit field when every bit from N-1 upward
    // is a copy of the sign, i.e. that slice is all-zero or all-one.
    always_comb begin
        imm_ok = 1'b1;
        case (in_type)
            FMT_I, FMT_S: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            FMT_B:        imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            FMT_J:        imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            FMT_U:        imm_ok = !(|in_imm[11:0]);
            default:      imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Handshakes. Rejected descriptors still complete the handshake so the
    // loader never stalls on a bad entry; they only leave a trace in err.
    // ------------------------------------------------------------------
    assign in_ready = (state == S_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && fmt_ok && imm_ok;
    assign drop     = accept && !(fmt_ok && imm_ok);

    assign imem_we    = !fifo_empty && ((state == S_LOAD) || (state == S_DRAIN));
    assign imem_addr  = addr;
    assign imem_wdata = fifo_head;
    assign pop        = imem_we && imem_ready;

    rv_inst_encoder_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (enc_dat),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .single   (fifo_single)
    );

    // ------------------------------------------------------------------
    // Session control, address counter and sticky error.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            addr  <= BASE_ADDR;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (pop) begin
                addr <= addr + 1'b1;
                // Running off the top of the address space is reported but
                // the write that hit the last word is still completed.
                if (&addr) begin
                    err <= 1'b1;
                end
            end
            if (drop) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_LOAD;
                        addr  <= BASE_ADDR;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && in_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Finish on the edge of the final pop so done is high in
                    // the very next cycle; nothing is pushed while draining.
                    if (fifo_empty || (pop && fifo_single)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_inst_encoder.sv
// Purpose: self-checking bench for rv_inst_encoder using a write scoreboard.
// Latency: expected writes are queued at descriptor acceptance and compared at each memory write.
// Backpressure: imem_ready is toggled by the stimulus to exercise FIFO fill and hold.
module tb_rv_inst_encoder;
    localparam int AW = 4;

    localparam logic [2:0] T_I = 3'd0;
    localparam logic [2:0] T_S = 3'd1;
    localparam logic [2:0] T_B = 3'd2;
    localparam logic [2:0] T_J = 3'd3;
    localparam logic [2:0] T_R = 3'd4;
    localparam logic [2:0] T_U = 3'd5;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_type = '0;
    logic [6:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic          imem_ready = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_addr = 0;
    int          q_addr[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    rv_inst_encoder #(
        .DEPTH     (4),
        .ADDR_W    (AW),
        .BASE_ADDR ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // addi rd,x0,imm built straight from the I-format layout.
    function automatic logic [31:0] addi_word(input int rd, input int imm);
        return 32'((imm << 20) | (rd << 7) | 32'h13);
    endfunction

    // Scoreboard consumer: every completed memory write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && imem_we && imem_ready) begin
            if (q_data.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("wr_addr", 32'(imem_addr), 32'(q_addr.pop_front()));
                chk("wr_data", imem_wdata, q_data.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic wr, input logic [31:0] word);
        int n = 0;
        in_type   = t;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (wr) begin
                q_addr.push_back(exp_addr);
                q_data.push_back(word);
                exp_addr = (exp_addr + 1) & ((1 << AW) - 1);
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = 0;
        chk("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single addi: offered the cycle after acceptance, done right after the write.
        do_start();
        chk("busy_load", 32'(busy), 32'd1);
        send(T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
        chk("addi_we", 32'(imem_we), 32'd1);
        chk("addi_word", imem_wdata, 32'h00500093);
        chk("addi_not_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("addi_done", 32'(done), 32'd1);
        chk("addi_idle_busy", 32'(busy), 32'd0);
        chk("addi_idle_ready", 32'(in_ready), 32'd0);

        // One of every format, back to back.
        do_start();
        send(T_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(T_R, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0, 1'b1, 32'h402081B3);
        send(T_S, OP_ST, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 1'b1, 32'h0020A423);
        send(T_B, OP_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
        send(T_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 1'b1, 32'h008000EF);
        send(T_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 1'b1, 32'h123452B7);
        wait_done();
        chk("fmt_err", 32'(err), 32'd0);

        // Memory stalled: four fill the FIFO, the fifth waits for a pop.
        do_start();
        imem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(T_I, OP_IMM, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, 1'b1, addi_word(k, k));
        end
        chk("full_ready_low", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_we", 32'(imem_we), 32'd1);
        chk("hold_addr", 32'(imem_addr), 32'd0);
        chk("hold_data", imem_wdata, addi_word(1, 1));
        imem_ready = 1'b1;
        send(T_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 1'b1, addi_word(5, 5));
        wait_done();

        // Illegal type mid-stream: dropped, err set, address untouched.
        do_start();
        send(T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b1, addi_word(1, 1));
        send(3'b110, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b0, 32'd0);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_we", 32'(imem_we), 32'd0);
        chk("illegal_addr", 32'(imem_addr), 32'd1);
        send(T_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, 1'b1, addi_word(3, 3));
        wait_done();
        chk("illegal_err_sticky", 32'(err), 32'd1);

        // Reset while draining flushes everything immediately.
        do_start();
        chk("start_clears_err", 32'(err), 32'd0);
        imem_ready = 1'b0;
        send(3'b111, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        send(T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b1, addi_word(1, 1));
        send(T_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1, 1'b1, addi_word(2, 2));
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_we", 32'(imem_we), 32'd1);
        chk("drain_err", 32'(err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        q_addr.delete();
        q_data.delete();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_ready = 1'b1;
        do_start();
        send(T_I, OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 1'b1, addi_word(7, 7));
        wait_done();

        // Address wrap: word 16 lands at 15, word 17 at 0, err raised.
        do_start();
        for (int k = 0; k < 17; k++) begin
            send(T_I, OP_IMM, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 100), 1'(k == 16), 1'b1,
                 addi_word(k, k + 100));
            if (k == 9) begin
                chk("pre_wrap_err", 32'(err), 32'd0);
            end
        end
        wait_done();
        chk("wrap_err", 32'(err), 32'd1);

        // Out-of-range addi immediate.
        do_start();
`ifdef RV_ENC_IMM_CHECK_EN
        send(T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0, 32'd0);
        wait_done();
        chk("imm_range_err", 32'(err), 32'd1);
`else
        send(T_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b1, 32'h80000093);
        wait_done();
        chk("imm_trunc_err", 32'(err), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(q_data.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
